// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - execute-stage issue sequencer driving the front end of a combinational ALU
//
// Accepts one decoded RV32E ALU op at a time, holds its operands in registers
// while the external ALU evaluates, captures the result and offers it to the
// register file on a valid/ready writeback port.
//
// Ports
//   clock, reset_n      single rising-edge clock, asynchronous active-low reset
//   issue_valid/ready   decode handshake; issue_op/a/b/rd carry the op
//   flush               synchronous kill of whatever is in flight
//   alu_a/alu_b         operands to the ALU (zero outside EXEC)
//   alu_operation       op code to the ALU (NONE outside EXEC)
//   alu_result          combinational ALU result, sampled at the end of EXEC
//   wb_valid/ready      writeback handshake towards the register file
//   wb_rd/data          destination register and result
//   wb_write_en         0 when the result must not be written
//   wb_illegal          op code was out of range; executed as NONE
//   ops_retired         count of completed writeback handshakes (wraps)

module alu_issue_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [3:0]             issue_op,
  input  logic [31:0]            issue_a,
  input  logic [31:0]            issue_b,
  input  logic [3:0]             issue_rd,
  input  logic                   flush,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_operation,
  input  logic [31:0]            alu_result,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [3:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic                   wb_write_en,
  output logic                   wb_illegal,
  output logic [COUNT_WIDTH-1:0] ops_retired
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LAST = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  state_t state;
  state_t next_state;

  // Low through reset and until the first clock edge after release, so the
  // issue port stays closed while the block is coming out of reset.
  logic running;

  // Operand registers: the only source of ALU inputs.
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  rd_q;
  logic        illegal_q;

  // Strobes decoded by the FSM.
  logic accept;   // issue handshake this cycle
  logic capture;  // latch ALU result into wb_* this cycle
  logic retire;   // writeback handshake this cycle

  logic issue_illegal;
  logic result_killed;

  assign issue_illegal = (issue_op > OP_LAST);
  // Results are zeroed both for illegal ops and for suppressed x0 writes.
  assign result_killed = illegal_q || (SUPPRESS_X0 && (rd_q == 4'd0));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    issue_ready   = 1'b0;
    wb_valid      = 1'b0;
    alu_a         = 32'd0;
    alu_b         = 32'd0;
    alu_operation = OP_NONE;
    capture       = 1'b0;
    retire        = 1'b0;
    accept        = 1'b0;

    case (state)
      S_IDLE: begin
        issue_ready = running;
      end
      S_EXEC: begin
        alu_a         = a_q;
        alu_b         = b_q;
        alu_operation = op_q;
        capture       = 1'b1;
        next_state    = S_WB;
      end
      S_WB: begin
        wb_valid    = 1'b1;
        // A new op may only enter when the current result leaves.
        issue_ready = wb_ready;
        retire      = wb_ready;
        if (wb_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // Flush overrides everything, including an issue or writeback handshake
    // that would otherwise complete in the same cycle.
    if (flush) begin
      issue_ready = 1'b0;
      capture     = 1'b0;
      retire      = 1'b0;
      next_state  = S_IDLE;
    end

    accept = issue_valid && issue_ready;
    if (accept) begin
      next_state = S_EXEC;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_NONE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rd_q        <= 4'd0;
      illegal_q   <= 1'b0;
      wb_rd       <= 4'd0;
      wb_data     <= 32'd0;
      wb_write_en <= 1'b0;
      wb_illegal  <= 1'b0;
    end else if (flush) begin
      op_q        <= OP_NONE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rd_q        <= 4'd0;
      illegal_q   <= 1'b0;
      wb_rd       <= 4'd0;
      wb_data     <= 32'd0;
      wb_write_en <= 1'b0;
      wb_illegal  <= 1'b0;
    end else begin
      if (accept) begin
        // Out-of-range codes never reach the ALU; they run as NONE.
        op_q      <= issue_illegal ? OP_NONE : issue_op;
        a_q       <= issue_a;
        b_q       <= issue_b;
        rd_q      <= issue_rd;
        illegal_q <= issue_illegal;
      end
      if (capture) begin
        wb_rd       <= rd_q;
        wb_data     <= result_killed ? 32'd0 : alu_result;
        wb_write_en <= !result_killed;
        wb_illegal  <= illegal_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-op counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ops_retired <= '0;
    end else if (retire) begin
      ops_retired <= ops_retired + COUNT_WIDTH'(1);
    end
  end

endmodule
